// File: rtl/t64_cag444torgb888_k8_mul_pipe.sv
// Pipelined operand multiplier for the CAG444->RGB888 colour datapath.
// Per-beat signedness on each operand, optional saturating narrow result,
// NUM_STAGE register stages (0 = combinational) with valid/ready backpressure.
module t64_cag444torgb888_k8_mul_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 8,
  parameter int din1_WIDTH = 9,
  parameter int dout_WIDTH = 17,
  parameter int SAT_EN     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  din0_signed,
  input  logic                  din1_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  sat
);

  // Full product width: one extra bit per operand keeps every mode exact.
  localparam int P = din0_WIDTH + din1_WIDTH + 1;

  logic signed [din0_WIDTH:0] a_ext;
  logic signed [din1_WIDTH:0] b_ext;
  logic signed [P-1:0]        prod;
  logic [dout_WIDTH-1:0]      fmt_d;
  logic                       fmt_s;

  // Unsigned operands get a zero top bit, signed ones replicate their MSB.
  assign a_ext = {din0_signed & din0[din0_WIDTH-1], din0};
  assign b_ext = {din1_signed & din1[din1_WIDTH-1], din1};
  // Both sides widened to P before multiplying; the exact product fits in P.
  assign prod  = P'(a_ext) * P'(b_ext);

  generate
    if (dout_WIDTH >= P) begin : g_ext
      assign fmt_d = dout_WIDTH'(prod);
      assign fmt_s = 1'b0;
    end else if (SAT_EN == 0) begin : g_wrap
      assign fmt_d = prod[dout_WIDTH-1:0];
      assign fmt_s = 1'b0;
    end else begin : g_sat
      localparam logic signed [P-1:0] MAX_V =
        {{(P-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
      localparam logic signed [P-1:0] MIN_V = ~MAX_V;
      // Clamp to the signed range of dout and flag the clamp.
      always_comb begin
        fmt_s = 1'b0;
        fmt_d = prod[dout_WIDTH-1:0];
        if (prod > MAX_V) begin
          fmt_d = MAX_V[dout_WIDTH-1:0];
          fmt_s = 1'b1;
        end else if (prod < MIN_V) begin
          fmt_d = MIN_V[dout_WIDTH-1:0];
          fmt_s = 1'b1;
        end
      end
    end

    if (NUM_STAGE < 0 || NUM_STAGE > 4) begin : g_bad
      $error("t64_cag444torgb888_k8_mul_pipe: NUM_STAGE must be in 0..4");
    end else if (NUM_STAGE == 0) begin : g_comb
      assign out_valid = in_valid && ce;
      assign in_ready  = out_ready && ce;
      assign dout      = fmt_d;
      assign sat       = fmt_s;
    end else begin : g_pipe
      logic [NUM_STAGE:1]    vld_pipe;
      logic [NUM_STAGE:1]    sat_pipe;
      logic [NUM_STAGE:1]    rdy;
      logic [dout_WIDTH-1:0] dat_pipe [1:NUM_STAGE];

      // A stage can load when it is empty or everything downstream moves.
      always_comb begin
        logic r;
        rdy = '0;
        r   = out_ready;
        for (int k = NUM_STAGE; k >= 1; k--) begin
          r      = !vld_pipe[k] || r;
          rdy[k] = r;
        end
      end

      // Stage registers; reset flushes in-flight beats, ce=0 freezes all.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_pipe <= '0;
          sat_pipe <= '0;
          for (int k = 1; k <= NUM_STAGE; k++) dat_pipe[k] <= '0;
        end else if (ce) begin
          if (rdy[1]) begin
            vld_pipe[1] <= in_valid;
            dat_pipe[1] <= fmt_d;
            sat_pipe[1] <= fmt_s;
          end
          for (int k = 2; k <= NUM_STAGE; k++) begin
            if (rdy[k]) begin
              vld_pipe[k] <= vld_pipe[k-1];
              dat_pipe[k] <= dat_pipe[k-1];
              sat_pipe[k] <= sat_pipe[k-1];
            end
          end
        end
      end

      assign in_ready  = ce && rdy[1];
      assign out_valid = vld_pipe[NUM_STAGE];
      assign dout      = dat_pipe[NUM_STAGE];
      assign sat       = sat_pipe[NUM_STAGE];
    end
  endgenerate

endmodule
